// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// The testbench imports this package as well as the RTL.
package mem_arbiter_pkg;

  localparam int STARVE_LIMIT_DEFAULT = 3;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CPU_ISSUE,
    ST_LD_ISSUE,
    ST_CPU_RESP,
    ST_LD_RESP
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_LD   = 2'b10
  } owner_t;

  // The counter holds its value once it reaches the limit.
  function automatic logic [1:0] starveNext(input logic [1:0] cnt, input logic [1:0] limit);
    return (cnt == limit) ? cnt : cnt + 2'd1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of CPU, loader and RAM signals around the memory arbiter.
// The arbiter is the slave; the requesters and the RAM sit on the master side.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_stall;

  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic [DATA_W-1:0] ld_rdata;
  logic              ld_ack;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              mem_we;
  logic [DATA_W-1:0] mem_dout;

  logic [1:0]        owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    input  mem_dout,
    output cpu_rdata, cpu_ack, cpu_stall,
    output ld_rdata, ld_ack,
    output mem_addr, mem_din, mem_we, owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ld_req, ld_we, ld_addr, ld_wdata,
    output mem_dout,
    input  cpu_rdata, cpu_ack, cpu_stall,
    input  ld_rdata, ld_ack,
    input  mem_addr, mem_din, mem_we, owner
  );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU and a program loader onto one synchronous single-port RAM.
// Each access takes an ISSUE cycle and a RESP cycle; a starvation counter lets the loader win contended IDLE decisions.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input logic        clk,
  input logic        reset,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] LIMIT = 2'(STARVE_LIMIT);

  state_t            state_q, state_d;
  logic [1:0]        starve_q, starve_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;

  logic              cpuAck, ldAck, memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memDin;
  owner_t            owner;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      starve_q    <= 2'd0;
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      cpu_rdata_q <= cpu_rdata_d;
      ld_rdata_q  <= ld_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    cpu_rdata_d = cpu_rdata_q;
    ld_rdata_d  = ld_rdata_q;
    cpuAck      = 1'b0;
    ldAck       = 1'b0;
    memWe       = 1'b0;
    memAddr     = '0;
    memDin      = '0;
    owner       = OWN_NONE;

    case (state_q)
      ST_IDLE: begin
        if (bus.cpu_req && !(bus.ld_req && starve_q == LIMIT))
          state_d = ST_CPU_ISSUE;
        else if (bus.ld_req)
          state_d = ST_LD_ISSUE;
      end
      ST_CPU_ISSUE: begin
        owner   = OWN_CPU;
        memWe   = bus.cpu_we;
        memAddr = bus.cpu_addr;
        memDin  = bus.cpu_wdata;
        state_d = ST_CPU_RESP;
      end
      ST_LD_ISSUE: begin
        owner   = OWN_LD;
        memWe   = bus.ld_we;
        memAddr = bus.ld_addr;
        memDin  = bus.ld_wdata;
        state_d = ST_LD_RESP;
      end
      // The requester just acked is ineligible, so only the other side can follow directly.
      ST_CPU_RESP: begin
        owner       = OWN_CPU;
        cpuAck      = 1'b1;
        cpu_rdata_d = bus.mem_dout;
        state_d     = bus.ld_req ? ST_LD_ISSUE : ST_IDLE;
      end
      ST_LD_RESP: begin
        owner      = OWN_LD;
        ldAck      = 1'b1;
        ld_rdata_d = bus.mem_dout;
        state_d    = bus.cpu_req ? ST_CPU_ISSUE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_LD_ISSUE)
      starve_d = 2'd0;
    else if (state_d == ST_CPU_ISSUE && bus.ld_req)
      starve_d = starveNext(starve_q, LIMIT);
  end

  assign bus.cpu_ack   = cpuAck;
  assign bus.ld_ack    = ldAck;
  assign bus.cpu_rdata = cpu_rdata_d;
  assign bus.ld_rdata  = ld_rdata_d;
  assign bus.cpu_stall = bus.cpu_req & ~cpuAck;
  assign bus.mem_we    = memWe;
  assign bus.mem_addr  = memAddr;
  assign bus.mem_din   = memDin;
  assign bus.owner     = owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a small synchronous RAM model.
// Inputs change and outputs are sampled around the falling clock edge.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT_DEFAULT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM, read-before-write, 256 words deep.
  logic [15:0] ram [0:255];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_din;
    bus.mem_dout <= ram[bus.mem_addr[7:0]];
  end

  task automatic idleInputs;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ld_req  = 1'b0; bus.ld_we  = 1'b0; bus.ld_addr  = '0; bus.ld_wdata  = '0;
  endtask

  task automatic test_reset;
    logic [67:0] got;
    #1;
    got = {bus.owner, bus.mem_we, bus.cpu_ack, bus.ld_ack, bus.mem_addr, bus.mem_din, bus.cpu_rdata};
    checks++;
    if (got !== 68'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got=%h want=0", got);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_cpu_write;
    logic [36:0] got;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0010; bus.cpu_wdata = 16'd100;
    #1;
    checks++;
    if ({bus.cpu_stall, bus.owner, bus.mem_we} !== {1'b1, 2'b00, 1'b0}) begin
      errors++;
      $display("[TB] FAIL wr_cycle0 got=%b%b%b want=1000", bus.cpu_stall, bus.owner, bus.mem_we);
    end
    @(negedge clk); #1;
    got = {bus.mem_we, bus.mem_addr, bus.mem_din, bus.owner, bus.cpu_stall, bus.cpu_ack};
    checks++;
    if (got !== {1'b1, 16'h0010, 16'd100, 2'b01, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL wr_issue got=%h want=%h", got, {1'b1, 16'h0010, 16'd100, 2'b01, 1'b1, 1'b0});
    end
    @(negedge clk); #1;
    checks++;
    if ({bus.cpu_ack, bus.cpu_stall, bus.owner, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 2'b01, 1'b0, 16'h0000}) begin
      errors++;
      $display("[TB] FAIL wr_resp ack=%b stall=%b owner=%b we=%b addr=%h want ack=1 stall=0 owner=01 we=0 addr=0000",
               bus.cpu_ack, bus.cpu_stall, bus.owner, bus.mem_we, bus.mem_addr);
    end
    idleInputs();
    @(negedge clk); #1;
    checks++;
    if ({bus.cpu_ack, bus.owner} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL wr_after ack=%b owner=%b want 0 00", bus.cpu_ack, bus.owner);
    end
  endtask

  task automatic test_cpu_read;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010;
    @(negedge clk); #1;
    checks++;
    if ({bus.cpu_ack, bus.mem_we, bus.mem_addr} !== {1'b0, 1'b0, 16'h0010}) begin
      errors++;
      $display("[TB] FAIL rd_issue ack=%b we=%b addr=%h want 0 0 0010", bus.cpu_ack, bus.mem_we, bus.mem_addr);
    end
    @(negedge clk); #1;
    checks++;
    if ({bus.cpu_ack, bus.cpu_rdata} !== {1'b1, 16'd100}) begin
      errors++;
      $display("[TB] FAIL rd_resp ack=%b rdata=%0d want 1 100", bus.cpu_ack, bus.cpu_rdata);
    end
    idleInputs();
    @(negedge clk); #1;
    checks++;
    if ({bus.cpu_ack, bus.cpu_rdata} !== {1'b0, 16'd100}) begin
      errors++;
      $display("[TB] FAIL rd_hold ack=%b rdata=%0d want 0 100", bus.cpu_ack, bus.cpu_rdata);
    end
  endtask

  // Both requests held: grants alternate; both dropped in the last loader ISSUE still completes.
  task automatic test_contention;
    logic [1:0] expOwner [14];
    logic [1:0] expAck   [14];
    expOwner = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0};
    expAck   = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0010;
    bus.ld_req  = 1'b1; bus.ld_addr  = 16'h0010;
    for (int i = 0; i < 14; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 11) idleInputs();
      #1;
      checks++;
      if ({bus.owner, bus.cpu_ack, bus.ld_ack} !== {expOwner[i], expAck[i]}) begin
        errors++;
        $display("[TB] FAIL contend_c%0d owner=%b acks=%b%b want owner=%b acks=%b",
                 i, bus.owner, bus.cpu_ack, bus.ld_ack, expOwner[i], expAck[i]);
      end
    end
  endtask

  // Loader request withdrawn each time, so every contended decision happens in IDLE.
  task automatic test_starvation;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010;
      bus.ld_req  = 1'b1; bus.ld_we  = 1'b0; bus.ld_addr  = 16'h0010;
      @(negedge clk); #1;
      checks++;
      if (bus.owner !== ((k == 3) ? OWN_LD : OWN_CPU)) begin
        errors++;
        $display("[TB] FAIL starve_grant%0d owner=%b want %b", k, bus.owner, (k == 3) ? OWN_LD : OWN_CPU);
      end
      if (k < 3) bus.ld_req = 1'b0;
      @(negedge clk); #1;
      checks++;
      if ({bus.cpu_ack, bus.ld_ack} !== ((k == 3) ? 2'b01 : 2'b10)) begin
        errors++;
        $display("[TB] FAIL starve_ack%0d acks=%b%b want %b", k, bus.cpu_ack, bus.ld_ack, (k == 3) ? 2'b01 : 2'b10);
      end
      if (k < 3) bus.cpu_req = 1'b0;
      bus.ld_req = 1'b0;
    end
    @(negedge clk); #1;
    checks++;
    if (bus.owner !== OWN_CPU) begin
      errors++;
      $display("[TB] FAIL starve_cpu_follow owner=%b want 01", bus.owner);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.cpu_ack !== 1'b1) begin
      errors++;
      $display("[TB] FAIL starve_cpu_ack ack=%b want 1", bus.cpu_ack);
    end
    idleInputs();
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.ld_req = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (bus.owner !== OWN_CPU) begin
      errors++;
      $display("[TB] FAIL starve_cleared owner=%b want 01", bus.owner);
    end
    bus.ld_req = 1'b0;
    @(negedge clk);
    idleInputs();
  endtask

  task automatic test_loader_image;
    logic [15:0] expData;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      expData = 16'h1000 + 16'(i);
      bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 16'(i); bus.ld_wdata = expData;
      @(negedge clk); #1;
      checks++;
      if ({bus.owner, bus.mem_we, bus.mem_addr, bus.mem_din} !== {2'b10, 1'b1, 16'(i), expData}) begin
        errors++;
        $display("[TB] FAIL ld_issue%0d owner=%b we=%b addr=%h din=%h want 10 1 %h %h",
                 i, bus.owner, bus.mem_we, bus.mem_addr, bus.mem_din, 16'(i), expData);
      end
      @(negedge clk); #1;
      checks++;
      if (bus.ld_ack !== 1'b1) begin
        errors++;
        $display("[TB] FAIL ld_ack%0d ack=%b want 1", i, bus.ld_ack);
      end
      idleInputs();
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      expData = 16'h1000 + 16'(i);
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'(i);
      @(negedge clk);
      @(negedge clk); #1;
      checks++;
      if ({bus.cpu_ack, bus.cpu_rdata} !== {1'b1, expData}) begin
        errors++;
        $display("[TB] FAIL image_rd%0d ack=%b rdata=%h want 1 %h", i, bus.cpu_ack, bus.cpu_rdata, expData);
      end
      idleInputs();
    end
  endtask

  task automatic test_reset_mid_access;
    logic [67:0] got;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0020; bus.cpu_wdata = 16'hBEEF;
    @(negedge clk); #1;
    checks++;
    if ({bus.owner, bus.mem_we} !== 3'b011) begin
      errors++;
      $display("[TB] FAIL rst_pre owner=%b we=%b want 01 1", bus.owner, bus.mem_we);
    end
    #2 reset = 1'b0;
    #1;
    got = {bus.owner, bus.mem_we, bus.cpu_ack, bus.ld_ack, bus.mem_addr, bus.mem_din, bus.cpu_rdata};
    checks++;
    if (got !== 68'd0 || bus.ld_rdata !== 16'd0) begin
      errors++;
      $display("[TB] FAIL rst_async got=%h ld_rdata=%h want 0", got, bus.ld_rdata);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.cpu_ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_noack ack=%b want 0", bus.cpu_ack);
    end
    idleInputs();
    reset = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({bus.owner, bus.cpu_ack} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL rst_release owner=%b ack=%b want 00 0", bus.owner, bus.cpu_ack);
    end
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010;
    @(negedge clk); #1;
    checks++;
    if ({bus.cpu_ack, bus.owner} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL rst_fresh_issue ack=%b owner=%b want 0 01", bus.cpu_ack, bus.owner);
    end
    @(negedge clk); #1;
    checks++;
    if ({bus.cpu_ack, bus.cpu_rdata} !== {1'b1, 16'd100}) begin
      errors++;
      $display("[TB] FAIL rst_fresh_ack ack=%b rdata=%0d want 1 100", bus.cpu_ack, bus.cpu_rdata);
    end
    idleInputs();
  endtask

  initial begin
    $display("[TB] mem_arbiter directed test start");
    idleInputs();
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_contention();
    test_starvation();
    test_loader_image();
    test_reset_mid_access();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
